// File: rtl/grid_access_arbiter.sv
// Round-robin arbiter sharing the single port of the level-grid RAM, with per-requester
// lock for atomic read-modify-write sequences and a tagged read-return path.
module grid_access_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int X_W        = 6,
  parameter int Y_W        = 5,
  parameter int D_W        = 3,
  parameter int RD_LATENCY = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     req_lock,
  input  logic [NUM_REQ*X_W-1:0] req_x,
  input  logic [NUM_REQ*Y_W-1:0] req_y,
  input  logic [NUM_REQ-1:0]     req_write,
  input  logic [NUM_REQ*D_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     rvalid,
  output logic [D_W-1:0]         rdata,
  output logic [X_W-1:0]         grid_x,
  output logic [Y_W-1:0]         grid_y,
  output logic                   grid_write,
  output logic [D_W-1:0]         grid_in,
  input  logic [D_W-1:0]         grid_out
);

  // Handshake: a requester raises req[i] with its fields and holds them stable until it
  // sees gnt[i]; in the gnt cycle it either drops req[i] or presents its next access.
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   lock_id;
  logic               lock_valid;
  logic [NUM_REQ-1:0] elig;
  logic               found;
  logic [IDX_W-1:0]   win;
  logic [IDX_W-1:0]   next_ptr;
  logic [NUM_REQ-1:0] win_onehot;

  logic [NUM_REQ-1:0] tag_pipe [RD_LATENCY];

  // A requester on the port this cycle sits out the next edge.
  always_comb begin
    int idx;
    idx   = 0;
    elig  = req & ~gnt;
    found = 1'b0;
    win   = '0;
    if (lock_valid) begin
      found = elig[lock_id];
      win   = lock_id;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = int'(ptr) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (!found && elig[idx]) begin
          found = 1'b1;
          win   = IDX_W'(idx);
        end
      end
    end
  end

  always_comb begin
    win_onehot = NUM_REQ'(1) << win;
    if (win == IDX_W'(NUM_REQ - 1)) next_ptr = '0;
    else                            next_ptr = win + 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      gnt        <= '0;
      grid_write <= 1'b0;
      grid_x     <= '0;
      grid_y     <= '0;
      grid_in    <= '0;
      ptr        <= '0;
      lock_valid <= 1'b0;
      lock_id    <= '0;
    end else begin
      gnt        <= found ? win_onehot : '0;
      grid_write <= found & req_write[win];
      if (found) begin
        grid_x     <= req_x[int'(win)*X_W +: X_W];
        grid_y     <= req_y[int'(win)*Y_W +: Y_W];
        grid_in    <= req_wdata[int'(win)*D_W +: D_W];
        ptr        <= next_ptr;
        lock_valid <= req_lock[win];
        lock_id    <= win;
      end
    end
  end

  // Read tags ride alongside the RAM pipeline so rvalid lines up with grid_out.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RD_LATENCY; i++) tag_pipe[i] <= '0;
    end else begin
      tag_pipe[0] <= gnt & {NUM_REQ{~grid_write}};
      for (int i = 1; i < RD_LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  assign rvalid = tag_pipe[RD_LATENCY-1];
  assign rdata  = grid_out;

endmodule

// File: tb/tb_grid_access_arbiter.sv
// Directed bench for grid_access_arbiter: one instance with RD_LATENCY=1 and a
// second with RD_LATENCY=2, each attached to a small grid RAM model.
module tb_grid_access_arbiter;

  localparam int N  = 3;
  localparam int XW = 6;
  localparam int YW = 5;
  localparam int DW = 3;

  logic clock = 1'b0;
  logic reset = 1'b0;

  logic [N-1:0]    req = '0, req_lock = '0, req_write = '0;
  logic [N*XW-1:0] req_x = '0;
  logic [N*YW-1:0] req_y = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]    gnt, rvalid;
  logic [DW-1:0]   rdata, grid_in, grid_out;
  logic [XW-1:0]   grid_x;
  logic [YW-1:0]   grid_y;
  logic            grid_write;

  logic [N-1:0]    req_b = '0;
  logic [N*XW-1:0] req_x_b = '0;
  logic [N*YW-1:0] req_y_b = '0;
  logic [N-1:0]    gnt_b, rvalid_b;
  logic [DW-1:0]   rdata_b, grid_in_b, grid_out_b;
  logic [XW-1:0]   grid_x_b;
  logic [YW-1:0]   grid_y_b;
  logic            grid_write_b;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  grid_access_arbiter #(.NUM_REQ(N), .X_W(XW), .Y_W(YW), .D_W(DW), .RD_LATENCY(1)) dut (
    .clock(clock), .reset(reset), .req(req), .req_lock(req_lock), .req_x(req_x),
    .req_y(req_y), .req_write(req_write), .req_wdata(req_wdata), .gnt(gnt),
    .rvalid(rvalid), .rdata(rdata), .grid_x(grid_x), .grid_y(grid_y),
    .grid_write(grid_write), .grid_in(grid_in), .grid_out(grid_out)
  );

  grid_access_arbiter #(.NUM_REQ(N), .X_W(XW), .Y_W(YW), .D_W(DW), .RD_LATENCY(2)) dut_b (
    .clock(clock), .reset(reset), .req(req_b), .req_lock(3'b000), .req_x(req_x_b),
    .req_y(req_y_b), .req_write(3'b000), .req_wdata(9'd0), .gnt(gnt_b),
    .rvalid(rvalid_b), .rdata(rdata_b), .grid_x(grid_x_b), .grid_y(grid_y_b),
    .grid_write(grid_write_b), .grid_in(grid_in_b), .grid_out(grid_out_b)
  );

  // Grid RAM model: unwritten cells hold (x+y) mod 8; written cells overlay that.
  logic [DW-1:0] wr_mem [0:63][0:31];
  logic          wr_vld [0:63][0:31];
  logic [DW-1:0] rd1, rd2a, rd2b;

  always @(posedge clock) begin
    if (!reset) begin
      for (int x = 0; x < 64; x++)
        for (int y = 0; y < 32; y++) wr_vld[x][y] <= 1'b0;
    end else if (grid_write) begin
      wr_mem[grid_x][grid_y] <= grid_in;
      wr_vld[grid_x][grid_y] <= 1'b1;
    end
    rd1  <= wr_vld[grid_x][grid_y] ? wr_mem[grid_x][grid_y] : 3'(grid_x + grid_y);
    rd2a <= 3'(grid_x_b + grid_y_b);
    rd2b <= rd2a;
  end

  assign grid_out   = rd1;
  assign grid_out_b = rd2b;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int i, input logic [XW-1:0] x, input logic [YW-1:0] y,
                         input logic wr, input logic [DW-1:0] d, input logic lk);
    req_x[i*XW +: XW]     = x;
    req_y[i*YW +: YW]     = y;
    req_write[i]          = wr;
    req_wdata[i*DW +: DW] = d;
    req_lock[i]           = lk;
  endtask

  task automatic set_b(input int i, input logic [XW-1:0] x, input logic [YW-1:0] y);
    req_x_b[i*XW +: XW] = x;
    req_y_b[i*YW +: YW] = y;
  endtask

  task automatic test_reset;
    tick;
    tick;
    checks++; if (gnt !== 3'b000) begin failures++; $display("FAIL reset_gnt got=%b exp=000", gnt); end
    checks++; if (rvalid !== 3'b000) begin failures++; $display("FAIL reset_rvalid got=%b exp=000", rvalid); end
    checks++; if ({grid_x, grid_y, grid_write, grid_in} !== 15'd0) begin
      failures++; $display("FAIL reset_grid got x=%0d y=%0d w=%b in=%0d exp all 0", grid_x, grid_y, grid_write, grid_in);
    end
    checks++; if ({gnt_b, rvalid_b} !== 6'd0) begin failures++; $display("FAIL reset_b got gnt=%b rvalid=%b exp 0", gnt_b, rvalid_b); end
    reset = 1'b1;
    tick;
  endtask

  task automatic test_single_read;
    set_req(0, 6'd5, 5'd7, 1'b0, 3'd0, 1'b0);
    req = 3'b001;
    tick;
    checks++; if (gnt !== 3'b001) begin failures++; $display("FAIL single_gnt got=%b exp=001", gnt); end
    checks++; if ({grid_x, grid_y, grid_write} !== {6'd5, 5'd7, 1'b0}) begin
      failures++; $display("FAIL single_addr got x=%0d y=%0d w=%b exp x=5 y=7 w=0", grid_x, grid_y, grid_write);
    end
    req = 3'b000;
    tick;
    checks++; if (rvalid !== 3'b001) begin failures++; $display("FAIL single_rvalid got=%b exp=001", rvalid); end
    checks++; if (rdata !== 3'd4) begin failures++; $display("FAIL single_rdata got=%0d exp=4", rdata); end
    checks++; if (gnt !== 3'b000) begin failures++; $display("FAIL single_gnt_drop got=%b exp=000", gnt); end
  endtask

  // Pointer sits at 1 after the single read, so the rotation starts with requester 1.
  task automatic test_round_robin;
    logic [2:0] exp_g [0:4];
    logic [2:0] exp_v;
    logic [2:0] exp_d;
    exp_g = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    set_req(0, 6'd1, 5'd1, 1'b0, 3'd0, 1'b0);
    set_req(1, 6'd2, 5'd2, 1'b0, 3'd0, 1'b0);
    set_req(2, 6'd3, 5'd3, 1'b0, 3'd0, 1'b0);
    req = 3'b111;
    for (int c = 0; c < 6; c++) begin
      tick;
      exp_v = (c == 0) ? 3'b000 : exp_g[c-1];
      exp_d = (exp_v == 3'b001) ? 3'd2 : (exp_v == 3'b010) ? 3'd4 : 3'd6;
      if (c < 5) begin
        checks++; if (gnt !== exp_g[c]) begin failures++; $display("FAIL rr_gnt[%0d] got=%b exp=%b", c, gnt, exp_g[c]); end
      end else begin
        checks++; if (gnt !== 3'b000) begin failures++; $display("FAIL rr_gnt_idle got=%b exp=000", gnt); end
      end
      checks++; if (rvalid !== exp_v) begin failures++; $display("FAIL rr_rvalid[%0d] got=%b exp=%b", c, rvalid, exp_v); end
      if (exp_v != 3'b000) begin
        checks++; if (rdata !== exp_d) begin failures++; $display("FAIL rr_rdata[%0d] got=%0d exp=%0d", c, rdata, exp_d); end
      end
      if (c == 4) req = 3'b000;
    end
  endtask

  task automatic test_lock;
    set_req(0, 6'd10, 5'd3, 1'b0, 3'd0, 1'b1);
    set_req(1, 6'd2, 5'd2, 1'b0, 3'd0, 1'b0);
    set_req(2, 6'd3, 5'd3, 1'b0, 3'd0, 1'b0);
    req = 3'b111;
    tick;
    checks++; if ({gnt, grid_x, grid_y, grid_write} !== {3'b001, 6'd10, 5'd3, 1'b0}) begin
      failures++; $display("FAIL lock_first got gnt=%b x=%0d y=%0d w=%b exp 001/10/3/0", gnt, grid_x, grid_y, grid_write);
    end
    set_req(0, 6'd11, 5'd3, 1'b1, 3'd4, 1'b0);
    tick;
    checks++; if ({gnt, grid_write} !== 4'b0000) begin failures++; $display("FAIL lock_block got gnt=%b w=%b exp 000/0", gnt, grid_write); end
    checks++; if ({rvalid, rdata} !== {3'b001, 3'd5}) begin
      failures++; $display("FAIL lock_read got rvalid=%b rdata=%0d exp 001/5", rvalid, rdata);
    end
    tick;
    checks++; if ({gnt, grid_x, grid_y, grid_write, grid_in} !== {3'b001, 6'd11, 5'd3, 1'b1, 3'd4}) begin
      failures++; $display("FAIL lock_write got gnt=%b x=%0d y=%0d w=%b in=%0d exp 001/11/3/1/4", gnt, grid_x, grid_y, grid_write, grid_in);
    end
    checks++; if (rvalid !== 3'b000) begin failures++; $display("FAIL lock_no_rvalid got=%b exp=000", rvalid); end
    req = 3'b110;
    tick;
    checks++; if (gnt !== 3'b010) begin failures++; $display("FAIL lock_release1 got=%b exp=010", gnt); end
    checks++; if (rvalid !== 3'b000) begin failures++; $display("FAIL write_no_rvalid got=%b exp=000", rvalid); end
    set_req(1, 6'd11, 5'd3, 1'b0, 3'd0, 1'b0);
    tick;
    checks++; if (gnt !== 3'b100) begin failures++; $display("FAIL lock_release2 got=%b exp=100", gnt); end
    checks++; if ({rvalid, rdata} !== {3'b010, 3'd4}) begin failures++; $display("FAIL lock_r1 got rvalid=%b rdata=%0d exp 010/4", rvalid, rdata); end
    req = 3'b010;
    tick;
    checks++; if ({gnt, grid_x} !== {3'b010, 6'd11}) begin failures++; $display("FAIL readback_gnt got gnt=%b x=%0d exp 010/11", gnt, grid_x); end
    checks++; if ({rvalid, rdata} !== {3'b100, 3'd6}) begin failures++; $display("FAIL lock_r2 got rvalid=%b rdata=%0d exp 100/6", rvalid, rdata); end
    req = 3'b000;
    tick;
    checks++; if ({rvalid, rdata} !== {3'b010, 3'd4}) begin
      failures++; $display("FAIL ram_written got rvalid=%b rdata=%0d exp 010/4", rvalid, rdata);
    end
  endtask

  task automatic test_back_to_back;
    set_req(2, 6'd20, 5'd10, 1'b1, 3'd1, 1'b0);
    req = 3'b100;
    for (int c = 0; c < 6; c++) begin
      tick;
      if (c % 2 == 0) begin
        checks++; if ({gnt, grid_write, grid_in} !== {3'b100, 1'b1, 3'(c / 2 + 1)}) begin
          failures++; $display("FAIL b2b_grant[%0d] got gnt=%b w=%b in=%0d exp 100/1/%0d", c, gnt, grid_write, grid_in, c / 2 + 1);
        end
        req_wdata[2*DW +: DW] = 3'(c / 2 + 2);
      end else begin
        checks++; if ({gnt, grid_write, grid_x} !== {3'b000, 1'b0, 6'd20}) begin
          failures++; $display("FAIL b2b_gap[%0d] got gnt=%b w=%b x=%0d exp 000/0/20", c, gnt, grid_write, grid_x);
        end
      end
      checks++; if (rvalid !== 3'b000) begin failures++; $display("FAIL b2b_rvalid[%0d] got=%b exp=000", c, rvalid); end
      if (c == 4) req = 3'b000;
    end
  endtask

  // Requester 1 takes a locked read so both pointer and owner are non-default before reset.
  task automatic test_reset_midread;
    set_req(1, 6'd5, 5'd7, 1'b0, 3'd0, 1'b1);
    req = 3'b010;
    tick;
    checks++; if (gnt !== 3'b010) begin failures++; $display("FAIL rst_pre_gnt got=%b exp=010", gnt); end
    req = 3'b000;
    reset = 1'b0;
    #1;
    checks++; if ({gnt, rvalid, grid_x, grid_y, grid_write, grid_in} !== 21'd0) begin
      failures++; $display("FAIL rst_async got gnt=%b rvalid=%b x=%0d y=%0d w=%b in=%0d exp all 0", gnt, rvalid, grid_x, grid_y, grid_write, grid_in);
    end
    tick;
    checks++; if (rvalid !== 3'b000) begin failures++; $display("FAIL rst_dropped_read got=%b exp=000", rvalid); end
    reset = 1'b1;
    set_req(1, 6'd0, 5'd0, 1'b0, 3'd0, 1'b0);
    set_req(0, 6'd1, 5'd1, 1'b0, 3'd0, 1'b0);
    set_req(2, 6'd3, 5'd3, 1'b0, 3'd0, 1'b0);
    req = 3'b101;
    tick;
    checks++; if (gnt !== 3'b001) begin failures++; $display("FAIL rst_first_grant got=%b exp=001", gnt); end
    checks++; if (rvalid !== 3'b000) begin failures++; $display("FAIL rst_no_rvalid got=%b exp=000", rvalid); end
    req = 3'b100;
    tick;
    checks++; if ({gnt, rvalid, rdata} !== {3'b100, 3'b001, 3'd2}) begin
      failures++; $display("FAIL rst_second got gnt=%b rvalid=%b rdata=%0d exp 100/001/2", gnt, rvalid, rdata);
    end
    req = 3'b000;
    tick;
    checks++; if ({rvalid, rdata} !== {3'b100, 3'd6}) begin failures++; $display("FAIL rst_third got rvalid=%b rdata=%0d exp 100/6", rvalid, rdata); end
  endtask

  // Access n uses cell (5n+1, 2n), whose model value is (7n+1) mod 8.
  task automatic test_latency2;
    logic [2:0] exp_g;
    logic [2:0] exp_v;
    set_b(0, 6'd1, 5'd0);
    set_b(1, 6'd6, 5'd2);
    req_b = 3'b011;
    for (int c = 0; c < 10; c++) begin
      tick;
      exp_g = (c < 8) ? ((c % 2 == 1) ? 3'b010 : 3'b001) : 3'b000;
      exp_v = (c >= 2) ? ((c % 2 == 1) ? 3'b010 : 3'b001) : 3'b000;
      checks++; if (gnt_b !== exp_g) begin failures++; $display("FAIL lat2_gnt[%0d] got=%b exp=%b", c, gnt_b, exp_g); end
      checks++; if (rvalid_b !== exp_v) begin failures++; $display("FAIL lat2_rvalid[%0d] got=%b exp=%b", c, rvalid_b, exp_v); end
      if (exp_v != 3'b000) begin
        checks++; if (rdata_b !== 3'(7 * (c - 2) + 1)) begin
          failures++; $display("FAIL lat2_rdata[%0d] got=%0d exp=%0d", c, rdata_b, 3'(7 * (c - 2) + 1));
        end
      end
      if (c < 8) set_b(c % 2, 6'(5 * (c + 2) + 1), 5'(2 * (c + 2)));
      if (c == 7) req_b = 3'b000;
    end
  endtask

  initial begin
    test_reset;
    test_single_read;
    test_round_robin;
    test_lock;
    test_back_to_back;
    test_reset_midread;
    test_latency2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
